// File: rtl/mem_stage_if.sv
// =============================================================================
// mem_stage_if : pipeline, data-cache and writeback signals of the MEM stage
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

interface mem_stage_if;
  // upstream pipeline
  logic        valid_i;
  logic        dREN_i;
  logic        dWEN_i;
  logic        halt_i;
  logic [31:0] addr_i;
  logic [31:0] store_i;
  logic [31:0] npc_i;
  logic [4:0]  rd_i;
  logic        regWr_i;
  logic [2:0]  rdSel_i;
  // data cache
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  // control and writeback
  logic        stall_o;
  logic        halt_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_regWr_o;
  logic [31:0] wb_data_o;
  logic        wb_halt_o;
  logic [15:0] mem_cycles_o;

  modport master (
    output valid_i, dREN_i, dWEN_i, halt_i, addr_i, store_i, npc_i,
           rd_i, regWr_i, rdSel_i, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall_o, halt_o,
           wb_valid_o, wb_rd_o, wb_regWr_o, wb_data_o, wb_halt_o, mem_cycles_o
  );

  modport slave (
    input  valid_i, dREN_i, dWEN_i, halt_i, addr_i, store_i, npc_i,
           rd_i, regWr_i, rdSel_i, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall_o, halt_o,
           wb_valid_o, wb_rd_o, wb_regWr_o, wb_data_o, wb_halt_o, mem_cycles_o
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// =============================================================================
// mem_stage : memory pipeline stage with data-cache handshake and writeback regs
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module mem_stage (
  input  logic        CLK,
  input  logic        nRST,
  mem_stage_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0]  C_SEL_NPC = 3'd2;
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic [4:0]  r_rd;
  logic        r_regwr;
  logic        r_is_store;
  logic        r_halt;
  logic        r_halt_pend;
  logic [15:0] r_cnt;

  logic        r_wb_valid;
  logic [4:0]  r_wb_rd;
  logic        r_wb_regwr;
  logic [31:0] r_wb_data;
  logic        r_wb_halt;

  logic        w_memop;
  logic [31:0] w_alu_data;
  logic        w_latch;
  logic        w_stall;
  logic        w_pend_next;
  logic        w_wb_valid;
  logic [4:0]  w_wb_rd;
  logic        w_wb_regwr;
  logic [31:0] w_wb_data;
  logic        w_wb_halt;

  assign w_memop    = bus.valid_i & (bus.dREN_i | bus.dWEN_i);
  assign w_alu_data = (bus.rdSel_i == C_SEL_NPC) ? bus.npc_i : bus.addr_i;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_stall     = 1'b0;
    w_pend_next = r_halt_pend;
    w_wb_valid  = 1'b0;
    w_wb_rd     = 5'd0;
    w_wb_regwr  = 1'b0;
    w_wb_data   = 32'd0;
    w_wb_halt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) begin
          w_latch = 1'b1;
          w_stall = 1'b1;
          w_next  = REQ;
        end else if (bus.valid_i && bus.halt_i) begin
          w_wb_valid = 1'b1;
          w_wb_halt  = 1'b1;
          w_wb_rd    = bus.rd_i;
          w_stall    = 1'b1;
          w_next     = HALTED;
        end else if (bus.valid_i) begin
          w_wb_valid = 1'b1;
          w_wb_rd    = bus.rd_i;
          w_wb_regwr = bus.regWr_i;
          w_wb_data  = w_alu_data;
        end
      end
      REQ: begin
        w_stall = ~bus.dhit;
        if (bus.dhit) begin
          w_wb_valid = 1'b1;
          w_wb_rd    = r_rd;
          w_wb_regwr = r_regwr & ~r_is_store;
          w_wb_data  = r_is_store ? r_addr : bus.dmemload;
          // a halt that rode along with the access is retired one cycle later
          if (r_halt) begin
            w_next      = HALTED;
            w_pend_next = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      HALTED: begin
        w_stall = 1'b1;
        if (r_halt_pend) begin
          w_wb_valid  = 1'b1;
          w_wb_halt   = 1'b1;
          w_pend_next = 1'b0;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_addr      <= 32'd0;
      r_store     <= 32'd0;
      r_rd        <= 5'd0;
      r_regwr     <= 1'b0;
      r_is_store  <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_pend <= 1'b0;
      r_cnt       <= 16'd0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_regwr  <= 1'b0;
      r_wb_data   <= 32'd0;
      r_wb_halt   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr     <= bus.addr_i;
        r_store    <= bus.store_i;
        r_rd       <= bus.rd_i;
        r_regwr    <= bus.regWr_i;
        r_is_store <= bus.dWEN_i;
        r_halt     <= bus.halt_i;
      end
      if ((r_state == REQ) && (r_cnt != C_CNT_MAX))
        r_cnt <= r_cnt + 16'd1;
      r_halt_pend <= w_pend_next;
      r_wb_valid  <= w_wb_valid;
      r_wb_rd     <= w_wb_rd;
      r_wb_regwr  <= w_wb_regwr;
      r_wb_data   <= w_wb_data;
      r_wb_halt   <= w_wb_halt;
    end
  end

  // cache requests come only from the latched copies, and only while in REQ
  assign bus.dmemREN      = (r_state == REQ) & ~r_is_store;
  assign bus.dmemWEN      = (r_state == REQ) &  r_is_store;
  assign bus.dmemaddr     = (r_state == REQ) ? r_addr : 32'd0;
  assign bus.dmemstore    = ((r_state == REQ) && r_is_store) ? r_store : 32'd0;

  assign bus.stall_o      = w_stall;
  assign bus.halt_o       = (r_state == HALTED);
  assign bus.wb_valid_o   = r_wb_valid;
  assign bus.wb_rd_o      = r_wb_rd;
  assign bus.wb_regWr_o   = r_wb_regwr;
  assign bus.wb_data_o    = r_wb_data;
  assign bus.wb_halt_o    = r_wb_halt;
  assign bus.mem_cycles_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// =============================================================================
// tb_mem_stage : scoreboard bench for mem_stage
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_mem_stage;

  logic CLK;
  logic nRST;
  mem_stage_if bus();

  mem_stage dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  typedef struct packed {
    logic [4:0]  rd;
    logic        regwr;
    logic [31:0] data;
    logic        halt;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(input logic [4:0] rd, input logic regwr,
                               input logic [31:0] data, input logic halt);
    wb_t e;
    e.rd = rd; e.regwr = regwr; e.data = data; e.halt = halt;
    sb.push_back(e);
  endfunction

  // writeback monitor: every valid record must match the head of the scoreboard
  always @(negedge CLK) begin
    if (bus.wb_valid_o) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_halt",  32'(bus.wb_halt_o),  32'(mon_e.halt));
        chk("wb_regWr", 32'(bus.wb_regWr_o), 32'(mon_e.regwr));
        if (!mon_e.halt) begin
          chk("wb_rd",   32'(bus.wb_rd_o), 32'(mon_e.rd));
          chk("wb_data", bus.wb_data_o,    mon_e.data);
        end
      end
    end else begin
      chk("bubble", {30'd0, bus.wb_regWr_o, bus.wb_halt_o}, 32'd0);
    end
  end

  task automatic idle_inputs();
    bus.valid_i = 1'b0; bus.dREN_i = 1'b0; bus.dWEN_i = 1'b0; bus.halt_i = 1'b0;
    bus.addr_i = 32'd0; bus.store_i = 32'd0; bus.npc_i = 32'd0;
    bus.rd_i = 5'd0; bus.regWr_i = 1'b0; bus.rdSel_i = 3'd0;
  endtask

  task automatic mem_op(input bit ld, input bit st, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] rd,
                        input bit hlt, input int lat, input logic [31:0] lv);
    bus.valid_i = 1'b1; bus.dREN_i = ld; bus.dWEN_i = st; bus.halt_i = hlt;
    bus.addr_i = a; bus.store_i = sd; bus.rd_i = rd; bus.regWr_i = 1'b1; bus.rdSel_i = 3'd0;
    if (st) push(rd, 1'b0, a, 1'b0);
    else    push(rd, 1'b1, lv, 1'b0);
    if (hlt) push(5'd0, 1'b0, 32'd0, 1'b1);
    @(negedge CLK);
    chk("issue_stall", 32'(bus.stall_o), 32'd1);
    chk("issue_noreq", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
    @(posedge CLK); #1;
    idle_inputs();
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin bus.dhit = 1'b1; bus.dmemload = lv; end
      @(negedge CLK);
      chk("req_ren",   32'(bus.dmemREN), 32'(!st));
      chk("req_wen",   32'(bus.dmemWEN), 32'(st));
      chk("req_addr",  bus.dmemaddr, a);
      if (st) chk("req_store", bus.dmemstore, sd);
      chk("req_stall", 32'(bus.stall_o), 32'(i != lat));
      @(posedge CLK); #1;
      bus.dhit = 1'b0; bus.dmemload = 32'd0;
    end
  endtask

  task automatic alu(input logic [31:0] a, input logic [31:0] npc,
                     input logic [2:0] sel, input logic [4:0] rd);
    bus.valid_i = 1'b1; bus.dREN_i = 1'b0; bus.dWEN_i = 1'b0; bus.halt_i = 1'b0;
    bus.addr_i = a; bus.npc_i = npc; bus.rdSel_i = sel; bus.rd_i = rd; bus.regWr_i = 1'b1;
    push(rd, 1'b1, (sel == 3'd2) ? npc : a, 1'b0);
    @(negedge CLK);
    chk("alu_stall", 32'(bus.stall_o), 32'd0);
    chk("alu_noreq", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    @(negedge CLK); #2;
    nRST = 1'b0;
    #1;
    sb.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    idle_inputs();
    bus.dhit = 1'b0; bus.dmemload = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_stall",  32'(bus.stall_o), 32'd0);
    chk("rst_halt",   32'(bus.halt_o), 32'd0);
    chk("rst_req",    32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
    chk("rst_addr",   bus.dmemaddr, 32'd0);
    chk("rst_wbv",    32'(bus.wb_valid_o), 32'd0);
    chk("rst_cycles", 32'(bus.mem_cycles_o), 32'd0);
    #2 nRST = 1'b1;
    @(posedge CLK); #1;

    // load, 3 REQ cycles
    mem_op(1'b1, 1'b0, 32'h100, 32'd0, 5'd5, 1'b0, 3, 32'hDEADBEEF);
    @(negedge CLK);
    chk("cycles_load", 32'(bus.mem_cycles_o), 32'd3);
    chk("post_load_ren", 32'(bus.dmemREN), 32'd0);
    @(posedge CLK); #1;

    // store, hit in first REQ cycle
    mem_op(1'b0, 1'b1, 32'h200, 32'h1234, 5'd6, 1'b0, 1, 32'd0);
    // both enables: store wins
    mem_op(1'b1, 1'b1, 32'h300, 32'hCAFE, 5'd7, 1'b0, 1, 32'h5555);
    @(negedge CLK);
    chk("cycles_acc", 32'(bus.mem_cycles_o), 32'd5);
    @(posedge CLK); #1;

    // back-to-back ALU ops
    alu(32'h0000_0A0A, 32'h44, 3'd0, 5'd8);
    alu(32'h0000_0B0B, 32'h44, 3'd2, 5'd9);
    alu(32'h0000_0C0C, 32'h48, 3'd1, 5'd10);
    idle_inputs();
    repeat (2) @(posedge CLK); #1;

    // reset in the middle of a pending load
    bus.valid_i = 1'b1; bus.dREN_i = 1'b1; bus.addr_i = 32'h400; bus.rd_i = 5'd3; bus.regWr_i = 1'b1;
    @(posedge CLK); #1;
    idle_inputs();
    @(negedge CLK);
    chk("midreq_ren", 32'(bus.dmemREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("async_ren",    32'(bus.dmemREN), 32'd0);
    chk("async_addr",   bus.dmemaddr, 32'd0);
    chk("async_cycles", 32'(bus.mem_cycles_o), 32'd0);
    sb.delete();
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("no_reissue", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
      chk("no_reissue_stall", 32'(bus.stall_o), 32'd0);
    end
    @(posedge CLK); #1;

    // load carrying a halt
    alu(32'h11, 32'h50, 3'd2, 5'd1);
    mem_op(1'b1, 1'b0, 32'h500, 32'd0, 5'd2, 1'b1, 2, 32'h0BADF00D);
    bus.valid_i = 1'b1; bus.dREN_i = 1'b1; bus.addr_i = 32'h600; bus.regWr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("halted_halt",  32'(bus.halt_o), 32'd1);
      chk("halted_stall", 32'(bus.stall_o), 32'd1);
      chk("halted_noreq", 32'({bus.dmemREN, bus.dmemWEN}), 32'd0);
    end
    idle_inputs();
    chk("sb_empty_halt", 32'(sb.size()), 32'd0);

    // halt without a memory access
    do_reset();
    @(negedge CLK);
    chk("reset_clears_halt", 32'(bus.halt_o), 32'd0);
    @(posedge CLK); #1;
    bus.valid_i = 1'b1; bus.halt_i = 1'b1; bus.rd_i = 5'd4; bus.regWr_i = 1'b1;
    push(5'd4, 1'b0, 32'd0, 1'b1);
    @(posedge CLK); #1;
    idle_inputs();
    repeat (2) begin
      @(negedge CLK);
      chk("halt_direct", 32'(bus.halt_o), 32'd1);
    end
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK in 1, clock; nRST in 1, reset, asynchronous, active-low.
REQ-002 SHALL have pipeline inputs: valid_i in 1, instr present; dREN_i in 1, load; dWEN_i in 1, store; halt_i in 1.
REQ-003 SHALL have inputs: addr_i in 32, ALU result/address; store_i in 32, store data; npc_i in 32, PC+4.
REQ-004 SHALL have inputs: rd_i in 5, dest reg; regWr_i in 1, reg write; rdSel_i in 3, writeback select.
REQ-005 SHALL have cache ports: dhit in 1, access done; dmemload in 32; dmemREN out 1; dmemWEN out 1; dmemaddr out 32; dmemstore out 32.
REQ-006 SHALL have control outputs: stall_o out 1, freeze upstream latches; halt_o out 1, sticky halt.
REQ-007 SHALL have writeback outputs: wb_valid_o 1; wb_rd_o 5; wb_regWr_o 1; wb_data_o 32; wb_halt_o 1.
REQ-008 SHALL have output mem_cycles_o 16, saturating count of cycles spent in REQ.

Function
REQ-009 SHALL implement FSM states IDLE, REQ, HALTED.
REQ-010 IDLE and valid_i&(dREN_i|dWEN_i): latch addr_i, store_i, rd_i, regWr_i, op type -> REQ; stall_o=1 that cycle; WB regs load bubble.
REQ-011 REQ: dmemREN/dmemWEN/dmemaddr/dmemstore driven only from latched copies; stall_o = !dhit.
REQ-012 REQ and dhit: WB regs load latched op (load: wb_data_o=dmemload; store: wb_regWr_o=0, wb_data_o=latched addr), wb_valid_o=1; -> IDLE.
REQ-013 REQ and !dhit: hold state, requests and WB bubble; mem_cycles_o +1 per REQ cycle, saturating at 16'hFFFF.
REQ-014 dREN_i and dWEN_i both set: store SHALL take priority; access treated as a store.
REQ-015 IDLE, valid_i, no mem op, !halt_i: WB regs load next edge, 1-cycle latency; stall_o=0.
REQ-016 Non-load wb_data_o SHALL be npc_i when rdSel_i==3'd2, else addr_i.
REQ-017 IDLE, valid_i, halt_i, no mem op: WB regs load wb_halt_o=1, wb_regWr_o=0, wb_valid_o=1 -> HALTED.
REQ-018 halt_i together with a mem op: the access SHALL complete first; halt SHALL be honoured on REQ exit as in REQ-017.
REQ-019 HALTED: halt_o=1, stall_o=1, no cache requests, WB bubble; exit only by reset.
REQ-020 valid_i=0 in IDLE: WB bubble (wb_valid_o=0, wb_regWr_o=0, wb_halt_o=0).
REQ-021 Cache outputs SHALL be 0 outside REQ.

Reset
REQ-022 nRST low SHALL immediately force state IDLE; all outputs, latched copies and mem_cycles_o to 0, including mid-REQ.
REQ-023 A request interrupted by reset SHALL NOT be reissued after reset release.

Verification
REQ-024 Load addr 0x100, dhit after 3 REQ cycles, dmemload=0xDEADBEEF -> dmemREN high 3 cycles; stall_o low on 3rd; next edge wb_data_o=0xDEADBEEF, wb_rd_o=rd_i; mem_cycles_o=3.
REQ-025 Store addr 0x200, store_i=0x1234, dhit 1st REQ cycle -> dmemWEN=1, dmemstore=0x1234 one cycle; wb_regWr_o=0.
REQ-026 Back-to-back ALU ops, rdSel_i=0 then 2 (npc_i=0x44) -> wb_data_o=addr_i, then 0x44, one cycle each, stall_o never high.
REQ-027 dREN_i=dWEN_i=1 -> only dmemWEN asserted.
REQ-028 halt_i with load -> load completes, then wb_halt_o=1 one cycle, halt_o stays 1, stall_o=1, no further requests.
REQ-029 nRST pulse mid-REQ -> dmemREN drops asynchronously; after release FSM IDLE, no request until new valid_i op.
